// File: rtl/neopixel_frame_ctrl.sv
// neopixel_frame_ctrl: frame sequencer for a WS2812 single-bit pixel writer.
// Keeps a local GRB colour buffer. On start it streams every pixel MSB-first
// over a value/valid/ready handshake, waits for the writer to drain, then
// holds the latch gap and pulses done.
// Optional build macro: NEOPIXEL_AUTO_REFRESH_EN adds the auto_refresh input,
// which chains frames back to back without a new start.
module neopixel_frame_ctrl #(
  parameter int NUM_PIXELS     = 8,
  parameter int ADDR_W         = 3,
  parameter int CLK_IN_RATE_HZ = 12_000_000,
  parameter int LATCH_US       = 80,
  parameter int LATCH_CYCLES   = CLK_IN_RATE_HZ / 1_000_000 * LATCH_US
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
`ifdef NEOPIXEL_AUTO_REFRESH_EN
  input  logic              auto_refresh,
`endif
  output logic              busy,
  output logic              done,
  output logic              bit_value,
  output logic              bit_valid,
  input  logic              bit_ready
);

  localparam int LCNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [LCNT_W-1:0] LATCH_LAST = LCNT_W'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DRAIN,
    ST_LATCH
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pix_idx_reg, pix_idx_next;
  logic [4:0]          bit_cnt_reg, bit_cnt_next;
  logic [23:0]         shift_reg, shift_next;
  logic [LCNT_W-1:0]   latch_cnt_reg, latch_cnt_next;
  logic [23:0]         load_word;
  logic [23:0]         pix_word [NUM_PIXELS];

  // Colour buffer: one register per pixel so reset can clear every entry.
  // An address outside the chain matches no entry and is dropped.
  generate
    for (genvar gi = 0; gi < NUM_PIXELS; gi++) begin : g_pix
      logic [23:0] word_reg;

      // Capture a host write addressed to this pixel.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          word_reg <= '0;
        end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
          word_reg <= wr_data;
        end
      end

      assign pix_word[gi] = word_reg;
    end
  endgenerate

  // Select the word for the current pixel; it is registered into the shifter in LOAD.
  always_comb begin
    load_word = '0;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      if (pix_idx_reg == ADDR_W'(i)) begin
        load_word = pix_word[i];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      pix_idx_reg   <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      latch_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pix_idx_reg   <= pix_idx_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      latch_cnt_reg <= latch_cnt_next;
    end
  end

  // Next-state and datapath update; a bit only advances on a valid&ready transfer.
  always_comb begin
    state_next     = state_reg;
    pix_idx_next   = pix_idx_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    latch_cnt_next = latch_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          pix_idx_next = '0;
          state_next   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_next   = load_word;
        bit_cnt_next = 5'd23;
        state_next   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_ready) begin
          if (bit_cnt_reg == 5'd0) begin
            if (pix_idx_reg == LAST_IDX) begin
              state_next = ST_DRAIN;
            end else begin
              pix_idx_next = pix_idx_reg + ADDR_W'(1);
              state_next   = ST_LOAD;
            end
          end else begin
            shift_next   = {shift_reg[22:0], 1'b0};
            bit_cnt_next = bit_cnt_reg - 5'd1;
          end
        end
      end
      ST_DRAIN: begin
        // Writer raises ready again once it has finished the last bit.
        if (bit_ready) begin
          latch_cnt_next = '0;
          state_next     = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (latch_cnt_reg == LATCH_LAST) begin
          state_next = ST_IDLE;
`ifdef NEOPIXEL_AUTO_REFRESH_EN
          if (auto_refresh) begin
            pix_idx_next = '0;
            state_next   = ST_LOAD;
          end
`endif
        end else begin
          latch_cnt_next = latch_cnt_reg + LCNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only, so they are stable through a stall.
  always_comb begin
    busy      = (state_reg != ST_IDLE);
    bit_valid = (state_reg == ST_SHIFT);
    bit_value = (state_reg == ST_SHIFT) && shift_reg[23];
    done      = (state_reg == ST_LATCH) && (latch_cnt_reg == LATCH_LAST);
  end

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// Testbench for neopixel_frame_ctrl: scoreboard of expected bits built from a
// model buffer, popped on each observed transfer.
module tb_neopixel_frame_ctrl;

  localparam int NP   = 2;
  localparam int AW   = 3;
  localparam int RATE = 1_000_000;
  localparam int LUS  = 20;
  localparam int LC   = RATE / 1_000_000 * LUS;

  logic          CLK = 1'b0;
  logic          RST;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          start;
  logic          bit_ready;
  logic          auto_refresh;
  logic          busy, done, bit_value, bit_valid;

  int n_checks = 0;
  int n_pass   = 0;

  bit          exp_q [$];
  logic [23:0] model [NP];
  int          ev_at [3];
  logic [AW-1:0] ev_a [3];
  logic [23:0] ev_d  [3];
  bit          ev_st [3];

  neopixel_frame_ctrl #(
    .NUM_PIXELS(NP), .ADDR_W(AW), .CLK_IN_RATE_HZ(RATE), .LATCH_US(LUS)
  ) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start),
`ifdef NEOPIXEL_AUTO_REFRESH_EN
    .auto_refresh(auto_refresh),
`endif
    .busy(busy), .done(done), .bit_value(bit_value), .bit_valid(bit_valid),
    .bit_ready(bit_ready)
  );

  always #5 CLK = ~CLK;

  task automatic clear_events();
    for (int k = 0; k < 3; k++) begin
      ev_at[k] = -1; ev_a[k] = '0; ev_d[k] = '0; ev_st[k] = 1'b0;
    end
  endtask

  task automatic push_frame();
    for (int p = 0; p < NP; p++)
      for (int b = 23; b >= 0; b--)
        exp_q.push_back(model[p][b]);
  endtask

  task automatic write_pix(input logic [AW-1:0] a, input logic [23:0] d);
    @(negedge CLK);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  // One full frame from start to done, with optional ready stalls and mid-frame events.
  task automatic run_frame(input string name, input int stall_max, input bit start_on_done);
    int xfer, cyc, nd, done_cnt, stall, exp_n;
    bit fin, held, held_v, exp_b;
    bit ev_done [3];
    xfer = 0; cyc = 0; nd = -1; done_cnt = 0; stall = 0; fin = 0; held = 0; held_v = 0;
    exp_n = exp_q.size();
    for (int k = 0; k < 3; k++) ev_done[k] = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s idle_busy: got %b want 0", name, busy); else n_pass++;
    start = 1'b1; bit_ready = 1'b1; wr_en = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || bit_valid !== 1'b0)
      $display("FAIL %s start_latency: busy=%b valid=%b want busy=1 valid=0", name, busy, bit_valid);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (bit_valid !== 1'b1) $display("FAIL %s first_valid: got %b want 1", name, bit_valid); else n_pass++;
    while (!fin && cyc < 6000 && !(nd >= 0 && cyc > nd + LC + 5)) begin
      if (stall > 0) begin bit_ready = 1'b0; stall--; end else bit_ready = 1'b1;
      wr_en = 1'b0; start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (!ev_done[k] && ev_at[k] >= 0 && xfer >= ev_at[k] && !wr_en) begin
          wr_en = 1'b1; wr_addr = ev_a[k]; wr_data = ev_d[k]; start = ev_st[k]; ev_done[k] = 1'b1;
        end
      end
      if (held) begin
        n_checks++;
        if (bit_valid !== 1'b1 || bit_value !== held_v)
          $display("FAIL %s stall_hold: valid=%b value=%b want valid=1 value=%b", name, bit_valid, bit_value, held_v);
        else n_pass++;
      end
      held = 1'b0;
      if (xfer == exp_n) begin
        n_checks++;
        if (bit_valid !== 1'b0) $display("FAIL %s drain_valid: got %b want 0", name, bit_valid); else n_pass++;
        if (nd < 0 && bit_ready) nd = cyc;
      end
      if (bit_valid === 1'b1 && bit_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s extra_bit: transfer %0d got %b want none", name, xfer, bit_value);
        end else begin
          exp_b = exp_q.pop_front();
          if (bit_value !== exp_b)
            $display("FAIL %s bit[%0d]: got %b want %b", name, xfer, bit_value, exp_b);
          else n_pass++;
        end
        xfer++;
        if (stall_max > 0 && $urandom_range(0, 1) == 1) stall = $urandom_range(0, stall_max);
      end else if (bit_valid === 1'b1) begin
        held = 1'b1; held_v = bit_value;
      end
      if (done === 1'b1) begin
        done_cnt++;
        n_checks++;
        if (nd < 0 || cyc != nd + LC)
          $display("FAIL %s done_time: got cycle %0d want %0d", name, cyc, nd + LC);
        else n_pass++;
        if (start_on_done) start = 1'b1;
        fin = 1'b1;
      end
      if (!fin) begin
        @(negedge CLK);
        cyc++;
      end
    end
    n_checks++;
    if (!fin) $display("FAIL %s done_missing: got no done want one", name); else n_pass++;
    n_checks++;
    if (xfer != exp_n) $display("FAIL %s xfer_count: got %0d want %0d", name, xfer, exp_n); else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s leftover: got %0d want 0", name, exp_q.size()); else n_pass++;
    @(negedge CLK);
    start = 1'b0; wr_en = 1'b0; bit_ready = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s after_done: busy=%b done=%b want 0 0", name, busy, done);
    else n_pass++;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s no_restart: busy=%b want 0", name, busy); else n_pass++;
    $display("frame %s: %0d transfers, %0d done, %0d cycles", name, xfer, done_cnt, cyc);
    exp_q.delete();
    clear_events();
  endtask

  task automatic test_reset();
    RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    bit_ready = 1'b1; auto_refresh = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({busy, done, bit_valid, bit_value} !== 4'b0000)
      $display("FAIL reset_outputs: got %b want 0000", {busy, done, bit_valid, bit_value});
    else n_pass++;
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({busy, done, bit_valid} !== 3'b000)
      $display("FAIL reset_release: got %b want 000", {busy, done, bit_valid});
    else n_pass++;
    $display("reset: outputs idle");
  endtask

  task automatic test_zero_frame();
    for (int p = 0; p < NP; p++) model[p] = 24'h000000;
    push_frame();
    run_frame("zero", 0, 1'b0);
  endtask

  task automatic test_pattern();
    write_pix(3'd0, 24'hA50F3C);
    write_pix(3'd1, 24'h800001);
    model[0] = 24'hA50F3C; model[1] = 24'h800001;
    push_frame();
    run_frame("pattern", 0, 1'b0);
  endtask

  task automatic test_stalls();
    push_frame();
    run_frame("stalls", 20, 1'b0);
  endtask

  task automatic test_midframe_writes();
    // pix1 not loaded yet: new value goes out now. pix0 already loaded: next frame.
    ev_at[0] = 5;  ev_a[0] = 3'd1; ev_d[0] = 24'h123456;
    ev_at[1] = 10; ev_a[1] = 3'd0; ev_d[1] = 24'hFFFF00;
    ev_at[2] = 15; ev_a[2] = 3'd7; ev_d[2] = 24'hFFFFFF; ev_st[2] = 1'b1;
    model[1] = 24'h123456;
    push_frame();
    run_frame("midframe_writes", 0, 1'b1);
    model[0] = 24'hFFFF00;
  endtask

  task automatic test_post_writes();
    push_frame();
    run_frame("post_writes", 6, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int xfer, cyc, done_cnt, busy_cnt;
    bit exp_b;
    xfer = 0; cyc = 0; done_cnt = 0; busy_cnt = 0;
    push_frame();
    @(negedge CLK); start = 1'b1; bit_ready = 1'b1;
    @(negedge CLK); start = 1'b0;
    while (xfer < 30 && cyc < 200) begin
      if (bit_valid === 1'b1) begin
        exp_b = exp_q.pop_front();
        n_checks++;
        if (bit_value !== exp_b) $display("FAIL rst_mid bit[%0d]: got %b want %b", xfer, bit_value, exp_b);
        else n_pass++;
        xfer++;
      end
      @(negedge CLK); cyc++;
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if ({busy, bit_valid, done} !== 3'b000)
      $display("FAIL rst_mid_abort: busy/valid/done=%b want 000", {busy, bit_valid, done});
    else n_pass++;
    exp_q.delete();
    for (int p = 0; p < NP; p++) model[p] = 24'h000000;
    @(negedge CLK); RST = 1'b0;
    repeat (60) begin
      @(negedge CLK);
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    n_checks++;
    if (done_cnt != 0 || busy_cnt != 0)
      $display("FAIL rst_mid_no_done: done=%0d busy=%0d want 0 0", done_cnt, busy_cnt);
    else n_pass++;
    $display("reset mid-frame after %0d transfers", xfer);
    push_frame();
    run_frame("zero_after_reset", 0, 1'b0);
  endtask

`ifdef NEOPIXEL_AUTO_REFRESH_EN
  task automatic test_auto_refresh();
    int xfer, cyc, done_cnt, busy_low;
    bit exp_b;
    xfer = 0; cyc = 0; done_cnt = 0; busy_low = 0;
    write_pix(3'd0, 24'h5A5A5A);
    write_pix(3'd1, 24'h0F00F0);
    model[0] = 24'h5A5A5A; model[1] = 24'h0F00F0;
    push_frame(); push_frame();
    auto_refresh = 1'b1;
    @(negedge CLK); start = 1'b1; bit_ready = 1'b1;
    @(negedge CLK); start = 1'b0;
    while (cyc < 3000 && done_cnt < 2) begin
      if (done_cnt >= 1) auto_refresh = 1'b0;
      if (busy !== 1'b1) busy_low++;
      if (bit_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL auto bit_extra: transfer %0d", xfer);
        end else begin
          exp_b = exp_q.pop_front();
          if (bit_value !== exp_b) $display("FAIL auto bit[%0d]: got %b want %b", xfer, bit_value, exp_b);
          else n_pass++;
        end
        xfer++;
      end
      if (done === 1'b1) done_cnt++;
      @(negedge CLK); cyc++;
    end
    n_checks++;
    if (done_cnt != 2) $display("FAIL auto_done_count: got %0d want 2", done_cnt); else n_pass++;
    n_checks++;
    if (xfer != 2 * 24 * NP) $display("FAIL auto_xfer: got %0d want %0d", xfer, 2 * 24 * NP); else n_pass++;
    n_checks++;
    if (busy_low != 0) $display("FAIL auto_busy_drop: got %0d low cycles want 0", busy_low); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL auto_stop: busy=%b want 0", busy); else n_pass++;
    repeat (5) @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0 || bit_valid !== 1'b0)
      $display("FAIL auto_stays_idle: busy=%b valid=%b want 0 0", busy, bit_valid);
    else n_pass++;
    $display("auto refresh: %0d transfers, %0d done", xfer, done_cnt);
    exp_q.delete();
  endtask
`endif

  initial begin
    clear_events();
    for (int p = 0; p < NP; p++) model[p] = 24'h000000;
    test_reset();
    test_zero_frame();
    test_pattern();
    test_stalls();
    test_midframe_writes();
    test_post_writes();
    test_reset_midframe();
`ifdef NEOPIXEL_AUTO_REFRESH_EN
    test_auto_refresh();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/neopixel_frame_ctrl.md
Name: neopixel_frame_ctrl

Overview:
- Frame sequencer for the WS2812 single-bit pixel writer.
- Holds a local pixel colour buffer. On start, streams every pixel's 24-bit GRB word MSB-first to the bit writer over a value/valid/ready handshake.
- After the last bit, waits for the writer to go idle, then holds a latch (reset) gap before reporting done.
- Sits between the host/pattern logic and the bit writer.

Parameters:
- NUM_PIXELS, 8, number of pixels in the chain (1..256).
- ADDR_W, 3, pixel address width; ceil(log2(NUM_PIXELS)), minimum 1.
- CLK_IN_RATE_HZ, 12_000_000, CLK frequency.
- LATCH_US, 80, latch gap in microseconds.
- LATCH_CYCLES, CLK_IN_RATE_HZ/1_000_000*LATCH_US, derived latch gap in CLK cycles (960 at defaults).

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  asynchronous, active-high reset.
- wr_en  input  1  buffer write strobe.
- wr_addr  input  ADDR_W  pixel index to write.
- wr_data  input  24  colour word {G[7:0],R[7:0],B[7:0]}.
- start  input  1  request one frame; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at end of latch gap.
- bit_value  output  1  bit to the writer.
- bit_valid  output  1  bit_value is valid.
- bit_ready  input  1  writer can accept a bit.

Behaviour:
- Reset (async, immediate):
  - busy=0, done=0, bit_valid=0, bit_value=0.
  - State=IDLE; pixel index, bit count and latch counter cleared.
  - All buffer entries cleared to 24'h000000.
- Buffer:
  - Write is synchronous on posedge when wr_en=1; allowed in any state.
  - wr_addr >= NUM_PIXELS is ignored.
  - A write to a pixel already loaded this frame takes effect next frame.
  - A write to a pixel not yet loaded takes effect this frame.
- Handshake:
  - A bit transfers on any posedge with bit_valid=1 and bit_ready=1.
  - bit_valid never drops and bit_value never changes until that bit transfers.
  - The next bit may be presented the cycle after a transfer.
- States:
  - IDLE: busy=0. If start=1, pixel index=0 and go to LOAD.
  - LOAD (1 cycle): shift reg <= buffer[pixel index], bit count=23, go to SHIFT.
    - First bit_valid appears 2 cycles after the start cycle.
  - SHIFT: bit_valid=1, bit_value=shift reg[23]. On transfer:
    - If bit count=0 and pixel index=NUM_PIXELS-1: go to DRAIN.
    - If bit count=0 otherwise: increment pixel index, go to LOAD.
    - Else: shift left, decrement bit count.
    - bit_valid is low in LOAD, so there is a 1-cycle bubble between pixels.
  - DRAIN: bit_valid=0; wait until bit_ready=1 (writer finished last bit), then clear latch counter and go to LATCH.
  - LATCH: bit_valid=0; count LATCH_CYCLES cycles. On the last count, pulse done=1 and go to IDLE.
- Rules:
  - start while busy is ignored (not queued).
  - done and a new start in the same cycle: start is not accepted; start must be sampled in IDLE.
  - Total transfers per frame = 24*NUM_PIXELS exactly.
  - Reset mid-frame aborts at once and no done is issued.

Optional Feature:
- Macro: NEOPIXEL_AUTO_REFRESH_EN.
- Defined:
  - Adds input auto_refresh (1 bit).
  - When auto_refresh=1 at the end of LATCH, done still pulses but the block goes straight to LOAD with pixel index=0.
  - busy stays 1 across frames.
  - When auto_refresh=0, behaviour is as normal.
- Undefined:
  - No auto_refresh port; each frame needs an explicit start.

Test Plan:
- Reset then start, NUM_PIXELS=2, buffer all 0 -> 48 transfers all bit_value=0; done pulses once, LATCH_CYCLES cycles after bit_ready returns high; busy then 0.
- Write pix0=24'hA50F3C, pix1=24'h800001; bit_ready held 1 -> bit stream 1010_0101_0000_1111_0011_1100_1000_0000_0000_0000_0000_0001; first bit_valid 2 cycles after start.
- Random bit_ready stalls (ready low 0-20 cycles) -> bit_value/bit_valid stable while stalled; no lost or duplicated bits; 48 transfers.
- Write pix1 while pix0 is shifting -> new pix1 value is sent; write pix0 during the same frame -> old value sent now, new value next frame; wr_addr=7 with NUM_PIXELS=2 -> ignored.
- start pulsed mid-frame and on the done cycle -> ignored, exactly one frame; RST asserted mid-SHIFT -> bit_valid=0 immediately, no done, buffer reads 0 on the next frame.
- With NEOPIXEL_AUTO_REFRESH_EN and auto_refresh=1 -> back-to-back frames, done pulse per frame, busy never drops; auto_refresh=0 -> stops after the current frame.
